// File: rtl/pipeline_hazard_controller_pkg.sv
// pipeline_hazard_controller_pkg: shared state encoding for the pipeline hazard sequencer
package pipeline_hazard_controller_pkg;
  typedef enum logic [1:0] {
    HZ_RUN      = 2'b00,
    HZ_MEM_WAIT = 2'b01,
    HZ_FLUSH    = 2'b10,
    HZ_BAD      = 2'b11
  } hz_state_t;
endpackage

// File: rtl/pipeline_hazard_controller_perf_counters.sv
// pipeline_hazard_controller_perf_counters: saturating stall/flush/load-use event counters (HAZARD_PERF_EN only)
`ifdef HAZARD_PERF_EN
module pipeline_hazard_controller_perf_counters #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             stall,
  input  logic             flush_ev,
  input  logic             lu_ev,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
  output logic [CNT_W-1:0] load_use_events
);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      stall_cycles    <= '0;
      flush_events    <= '0;
      load_use_events <= '0;
    end else begin
      if (stall && !(&stall_cycles)) stall_cycles <= stall_cycles + 1'b1;
      if (flush_ev && !(&flush_events)) flush_events <= flush_events + 1'b1;
      if (lu_ev && !(&load_use_events)) load_use_events <= load_use_events + 1'b1;
    end
endmodule
`endif

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: stall/flush sequencer for the 5-stage pipeline (load-use, branch squash, memory wait).
// Defining HAZARD_PERF_EN adds saturating stall/flush/load-use performance counters.
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int REG_AW       = 4,
  parameter int FLUSH_CYCLES = 1
`ifdef HAZARD_PERF_EN
  , parameter int CNT_W      = 16
`endif
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              ex_br_taken,
  input  logic              mem_req,
  input  logic              mem_ack,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              idex_write,
  output logic              exmem_write,
  output logic              ifid_flush,
  output logic              idex_flush,
`ifdef HAZARD_PERF_EN
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_events,
  output logic [CNT_W-1:0]  load_use_events,
`endif
  output logic [1:0]        ctrl_state
);
  hz_state_t  state, state_nx;
  logic [2:0] flush_cnt, flush_cnt_nx;
  logic       resume_flush, resume_nx;
  logic       load_use, stall_mem, run_mode, freeze, flush, br_acc, lu_acc;
  assign load_use  = ex_memread && ex_rd != '0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
  assign stall_mem = mem_req && !mem_ack;
  assign run_mode  = state == HZ_RUN || state == HZ_BAD;
  assign br_acc    = run_mode && !stall_mem && ex_br_taken;
  assign lu_acc    = run_mode && !stall_mem && !ex_br_taken && load_use;
  // MEM_WAIT freezes the whole pipe even on the ack cycle; held instructions replay afterwards
  assign freeze    = state == HZ_MEM_WAIT || stall_mem;
  assign flush     = !freeze && (state == HZ_FLUSH || br_acc);
  assign pc_write    = reset_n && !freeze && !lu_acc;
  assign ifid_write  = reset_n && !freeze && !lu_acc;
  assign idex_write  = reset_n && !freeze;
  assign exmem_write = reset_n && !freeze;
  assign ifid_flush  = !reset_n || flush;
  assign idex_flush  = !reset_n || flush || lu_acc;
  assign ctrl_state  = state;
  always_comb begin
    state_nx     = HZ_RUN;
    flush_cnt_nx = flush_cnt;
    resume_nx    = resume_flush;
    case (state)
      HZ_RUN: begin
        if (stall_mem) begin
          state_nx  = HZ_MEM_WAIT;
          resume_nx = 1'b0;
        end else if (ex_br_taken && FLUSH_CYCLES > 1) begin
          state_nx     = HZ_FLUSH;
          flush_cnt_nx = 3'(FLUSH_CYCLES - 1);
        end
      end
      HZ_MEM_WAIT: state_nx = !mem_ack ? HZ_MEM_WAIT : resume_flush ? HZ_FLUSH : HZ_RUN;
      HZ_FLUSH: begin
        if (stall_mem) begin
          state_nx  = HZ_MEM_WAIT;
          resume_nx = 1'b1;
        end else begin
          flush_cnt_nx = flush_cnt - 1'b1;
          state_nx     = flush_cnt > 3'd1 ? HZ_FLUSH : HZ_RUN;
        end
      end
      default: state_nx = HZ_RUN;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state        <= HZ_RUN;
      flush_cnt    <= '0;
      resume_flush <= 1'b0;
    end else begin
      state        <= state_nx;
      flush_cnt    <= flush_cnt_nx;
      resume_flush <= resume_nx;
    end
`ifdef HAZARD_PERF_EN
  pipeline_hazard_controller_perf_counters #(.CNT_W(CNT_W)) u_perf (
    .clock           (clock),
    .reset_n         (reset_n),
    .stall           (!pc_write),
    .flush_ev        (br_acc),
    .lu_ev           (lu_acc),
    .stall_cycles    (stall_cycles),
    .flush_events    (flush_events),
    .load_use_events (load_use_events)
  );
`endif
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller: directed self-checking bench for pipeline_hazard_controller (FLUSH_CYCLES=2)
module tb_pipeline_hazard_controller;
  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       ex_memread = 1'b0, ex_br_taken = 1'b0, mem_req = 1'b0, mem_ack = 1'b0;
  logic [3:0] ex_rd = '0, id_rs1 = '0, id_rs2 = '0;
  logic       pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_flush;
  logic [1:0] ctrl_state;
  logic [7:0] obs;
  int         vectors = 0;
  int         miscompares = 0;
`ifdef HAZARD_PERF_EN
  logic [3:0] stall_cycles, flush_events, load_use_events;
`endif
  // expected {ctrl_state, pc, ifid, idex, exmem, ifid_flush, idex_flush}
  localparam logic [7:0] E_RESET = 8'b00_000011;
  localparam logic [7:0] E_RUN   = 8'b00_111100;
  localparam logic [7:0] E_FRZ   = 8'b00_000000;
  localparam logic [7:0] E_BR    = 8'b00_111111;
  localparam logic [7:0] E_LU    = 8'b00_001101;
  localparam logic [7:0] E_MW    = 8'b01_000000;
  localparam logic [7:0] E_FL    = 8'b10_111111;
  localparam logic [7:0] E_FLFRZ = 8'b10_000000;

  always #5 clock = ~clock;

  pipeline_hazard_controller #(
    .REG_AW(4),
    .FLUSH_CYCLES(2)
`ifdef HAZARD_PERF_EN
    , .CNT_W(4)
`endif
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .ex_memread      (ex_memread),
    .ex_rd           (ex_rd),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .ex_br_taken     (ex_br_taken),
    .mem_req         (mem_req),
    .mem_ack         (mem_ack),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .idex_write      (idex_write),
    .exmem_write     (exmem_write),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
`ifdef HAZARD_PERF_EN
    .stall_cycles    (stall_cycles),
    .flush_events    (flush_events),
    .load_use_events (load_use_events),
`endif
    .ctrl_state      (ctrl_state)
  );

  assign obs = {ctrl_state, pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_flush};

  task automatic chk(input string tag, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step(input logic mr, input logic [3:0] rd, input logic [3:0] rs1, input logic [3:0] rs2,
                      input logic br, input logic req, input logic ack);
    @(posedge clock);
    #1;
    ex_memread = mr; ex_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    ex_br_taken = br; mem_req = req; mem_ack = ack;
    #1;
  endtask

  initial begin
    #1 chk("reset_hold", E_RESET);
    @(negedge clock);
    @(negedge clock) reset_n = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0); chk("run_idle", E_RUN);
    step(1, 3, 5, 3, 0, 0, 0); chk("load_use_rs2", E_LU);
    step(1, 0, 0, 0, 0, 0, 0); chk("rd0_no_stall", E_RUN);
    step(0, 3, 5, 3, 0, 0, 0); chk("not_load_no_stall", E_RUN);
    step(1, 7, 7, 2, 0, 0, 0); chk("load_use_rs1", E_LU);
    step(1, 7, 1, 2, 0, 0, 0); chk("load_no_match", E_RUN);
    step(0, 0, 0, 0, 1, 0, 0); chk("branch_c1", E_BR);
    step(0, 0, 0, 0, 0, 0, 0); chk("branch_c2", E_FL);
    step(0, 0, 0, 0, 0, 0, 0); chk("branch_done", E_RUN);
    step(0, 0, 0, 0, 0, 1, 0); chk("mem_stall_c1", E_FRZ);
    step(0, 0, 0, 0, 0, 1, 0); chk("mem_stall_c2", E_MW);
    step(0, 0, 0, 0, 0, 1, 1); chk("mem_ack_cycle", E_MW);
    step(0, 0, 0, 0, 0, 0, 0); chk("mem_after_ack", E_RUN);
    step(0, 0, 0, 0, 0, 1, 1); chk("zero_wait", E_RUN);
    step(1, 4, 4, 0, 1, 0, 0); chk("branch_over_lu", E_BR);
    step(1, 4, 4, 0, 0, 0, 0); chk("flush_ignores_lu", E_FL);
    step(0, 0, 0, 0, 0, 0, 0); chk("run_again", E_RUN);
    step(0, 0, 0, 0, 1, 1, 0); chk("stall_over_branch", E_FRZ);
    step(0, 0, 0, 0, 1, 1, 0); chk("mw_branch_held", E_MW);
    step(0, 0, 0, 0, 1, 1, 1); chk("mw_branch_ack", E_MW);
    step(0, 0, 0, 0, 1, 0, 0); chk("branch_after_ack", E_BR);
    step(0, 0, 0, 0, 0, 1, 0); chk("flush_mem_freeze", E_FLFRZ);
    step(0, 0, 0, 0, 0, 1, 1); chk("flush_mw_ack", E_MW);
    step(0, 0, 0, 0, 0, 0, 0); chk("flush_resumed", E_FL);
    step(0, 0, 0, 0, 0, 0, 0); chk("run_after_resume", E_RUN);
    step(0, 0, 0, 0, 0, 1, 0); chk("no_ack_enter", E_FRZ);
    for (int i = 0; i < 40; i++) begin
      step(0, 0, 0, 0, 0, 1, 0); chk("no_ack_hold", E_MW);
    end
    #2 reset_n = 1'b0;
    #1 chk("async_reset_mw", E_RESET);
    step(0, 0, 0, 0, 0, 0, 0); chk("reset_low_held", E_RESET);
    @(negedge clock) reset_n = 1'b1;
    #1 chk("reset_release", E_RUN);
    step(0, 0, 0, 0, 0, 0, 0); chk("post_reset_run", E_RUN);
`ifdef HAZARD_PERF_EN
    step(0, 0, 0, 0, 0, 0, 0);
    #2 reset_n = 1'b0;
    @(negedge clock) reset_n = 1'b1;
    step(1, 5, 5, 0, 0, 0, 0); chk("perf_lu", E_LU);
    step(0, 0, 0, 0, 1, 0, 0); chk("perf_br", E_BR);
    step(0, 0, 0, 0, 0, 0, 0); chk("perf_flush", E_FL);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    vectors++;
    assert (stall_cycles === 4'hF) else begin
      miscompares++;
      $error("FAIL perf_stall_sat: observed %h expected %h", stall_cycles, 4'hF);
    end
    vectors++;
    assert (flush_events === 4'h1) else begin
      miscompares++;
      $error("FAIL perf_flush_events: observed %h expected %h", flush_events, 4'h1);
    end
    vectors++;
    assert (load_use_events === 4'h1) else begin
      miscompares++;
      $error("FAIL perf_lu_events: observed %h expected %h", load_use_events, 4'h1);
    end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
